bcd_converter_seq: RTL and testbench
====================================

# bcd_converter_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one shift per clock. It replaces the fixed 8-bit combinational converter wherever wider operands or fewer gates are needed. Typical uses are display and debug paths, such as printing AES round counters or byte values. Both sides use valid/ready handshakes, and the block flags overflow when `DIGITS` is too small for the input value.

## Interface
- `BIN_W`, 8: binary input width, ≥ 1.
- `DIGITS`, 3: number of BCD output digits, ≥ 1. Full-range conversion without overflow requires 10^DIGITS > 2^BIN_W − 1.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_bin` holds a value to convert.
- `in_ready` output 1: block can accept a value; high exactly when the FSM is in IDLE.
- `in_bin` input `BIN_W`: unsigned binary operand, sampled only on accept.
- `out_valid` output 1: result available; high exactly when the FSM is in DONE.
- `out_ready` input 1: consumer takes the result.
- `out_bcd` output 4·`DIGITS`: BCD result; digit 0 (units) is in bits [3:0].
- `out_ovf` output 1: value ≥ 10^DIGITS. When set, `out_bcd` holds the value mod 10^DIGITS.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE:**
  - On `in_valid` (accept), load `in_bin` into the binary shift register.
  - Clear the BCD working register and the overflow accumulator.
  - Set the bit counter to `BIN_W`, then go to SHIFT.
- **SHIFT**, once per cycle:
  - For every digit of the working register, add 3 if the digit is ≥ 5 (4-bit wrap-free; the result is ≤ 12).
  - Shift the {BCD, binary} concatenation left by 1. The binary MSB enters BCD bit 0.
  - OR the bit shifted out of the top digit into the overflow accumulator.
  - Decrement the counter.
  - When the counter reaches 0 after this shift, copy the working register to `out_bcd` and the accumulator to `out_ovf`, then go to DONE.
- **DONE:**
  - Hold `out_valid` high with `out_bcd` and `out_ovf` stable.
  - On `out_ready`, go to IDLE.
  - Never drop `out_valid` without `out_ready`.
- `out_bcd` and `out_ovf` are separate output registers. They keep the last result after DONE is left, until the next conversion completes.
- Changes on `in_bin` or `in_valid` outside the accept cycle have no effect.
- `in_valid` during SHIFT or DONE is ignored; no queuing.
- Every output digit is in the range 0–9 for every input, including overflow cases.
- `BIN_W` = 1 is legal: one SHIFT cycle.

## Timing
- **Reset (`rst_n` low, asynchronous, any state):**
  - FSM goes to IDLE; counter, working registers and accumulator are cleared.
  - Output values: `out_valid` = 0, `out_bcd` = 0, `out_ovf` = 0, `in_ready` = 1.
  - Any conversion in flight is discarded, with no partial result exposed.
- Accept happens at rising edge E0, when IDLE and `in_valid` are both high.
- SHIFT occupies edges E1 … E`BIN_W`.
- `out_valid` rises after edge E`BIN_W`, i.e. `BIN_W` cycles after accept.
- Minimum spacing between accepts is `BIN_W` + 2 cycles: one DONE cycle with `out_ready` high, then one IDLE cycle.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- With `out_ready` held high in DONE, exactly one handshake occurs and `out_valid` lasts exactly one cycle.

## Test plan
- `BIN_W` = 8, `DIGITS` = 3:
  - Inputs 0, 1, 45, 100, 156, 251, 255 → `out_bcd` 0x000, 0x001, 0x045, 0x100, 0x156, 0x251, 0x255.
  - `out_ovf` = 0 for all.
  - `out_valid` rises exactly 8 cycles after each accept.
- `BIN_W` = 8, `DIGITS` = 2:
  - 99 → 0x99, `out_ovf` 0.
  - 100 → 0x00, `out_ovf` 1.
  - 200 → 0x00, `out_ovf` 1.
  - 255 → 0x55, `out_ovf` 1.
- `BIN_W` = 16, `DIGITS` = 5:
  - 65535 → 0x65535, `out_ovf` 0, latency 16.
  - 10000 → 0x10000.
  - 9 → 0x00009.
- Backpressure and ignored inputs (`BIN_W` = 8, `DIGITS` = 3):
  - Convert 123, hold `out_ready` low for 5 cycles, toggling `in_valid` and `in_bin` throughout.
  - Required: `out_valid` stays high, `out_bcd` stays 0x123, `in_ready` stays 0, and no second conversion starts.
  - Raise `out_ready` → one handshake, then `in_ready` returns to 1 the next cycle.
- Reset mid-conversion:
  - Accept 255, assert `rst_n` low after 4 SHIFT cycles, asynchronously between edges.
  - Required: outputs reach their reset values immediately.
  - After release, convert 42 → 0x042, `out_ovf` 0.
- Back-to-back stream:
  - 50 random 8-bit values with `in_valid` and `out_ready` held high.
  - Required: each result matches a decimal reference model, and accepts are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock)
// with valid/ready handshakes on both sides and an overflow flag.
module bcd_converter_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic [1:0]            dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Handshake rule: a transfer happens on a rising edge where valid and
    // ready are both high; ready/valid here depend on registered state only.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_ovf_q, out_ovf_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_sh;
    logic               ovf_sh;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        // The bit leaving the top digit is the carry into a digit we do not keep.
        bcd_sh = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        ovf_sh = ovf_q | adj[BCD_W-1];
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_sh;
                ovf_d = ovf_sh;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_bcd_d = bcd_sh;
                    out_ovf_d = ovf_sh;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_bcd_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            out_bcd_q <= out_bcd_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_bcd   = out_bcd_q;
    assign out_ovf   = out_ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Bench for bcd_converter_seq: three configurations (8/3, 8/2, 16/5) sharing
// one clock and reset, checked against a decimal reference model.
module tb_bcd_converter_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_bin;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ovf;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [19:0] bcd_c;
    logic [1:0]  dbg_a, dbg_b, dbg_c;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_converter_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bin(in_bin[7:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bcd(bcd_a), .out_ovf(out_ovf[0]), .dbg_state(dbg_a));

    bcd_converter_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bin(in_bin[7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bcd(bcd_b), .out_ovf(out_ovf[1]), .dbg_state(dbg_b));

    bcd_converter_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bin(in_bin), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_bcd(bcd_c), .out_ovf(out_ovf[2]), .dbg_state(dbg_c));

    typedef struct {
        int          sel;
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    // Decimal reference: repeated divide-by-ten; whatever remains is overflow.
    function automatic logic [20:0] ref_bcd(input int unsigned v, input int digits);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {(x != 0), r};
    endfunction

    function automatic logic [19:0] get_bcd(input int sel);
        case (sel)
            0:       return {8'h0, bcd_a};
            1:       return {12'h0, bcd_b};
            default: return bcd_c;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int sel, input logic [15:0] v,
                           output logic [19:0] bcd, output logic ovf, output int lat);
        int guard;
        guard = 0;
        while (!in_ready[sel] && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 32'(in_ready[sel]), 32'd1);
        in_bin        = v;
        in_valid[sel] = 1'b1;
        tick();
        in_valid[sel] = 1'b0;
        lat = 0;
        while (!out_valid[sel] && lat < 100) begin
            tick();
            lat++;
        end
        bcd = get_bcd(sel);
        ovf = out_ovf[sel];
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] bcd;
        logic        ovf;
        logic [20:0] exp;
        int          lat;
        logic [7:0]  r;
        logic [15:0] r16;

        vecs[0]  = '{0, 16'd0,     20'h00000, 1'b0, 8};
        vecs[1]  = '{0, 16'd1,     20'h00001, 1'b0, 8};
        vecs[2]  = '{0, 16'd45,    20'h00045, 1'b0, 8};
        vecs[3]  = '{0, 16'd100,   20'h00100, 1'b0, 8};
        vecs[4]  = '{0, 16'd156,   20'h00156, 1'b0, 8};
        vecs[5]  = '{0, 16'd251,   20'h00251, 1'b0, 8};
        vecs[6]  = '{0, 16'd255,   20'h00255, 1'b0, 8};
        vecs[7]  = '{1, 16'd99,    20'h00099, 1'b0, 8};
        vecs[8]  = '{1, 16'd100,   20'h00000, 1'b1, 8};
        vecs[9]  = '{1, 16'd200,   20'h00000, 1'b1, 8};
        vecs[10] = '{1, 16'd255,   20'h00055, 1'b1, 8};
        vecs[11] = '{2, 16'd65535, 20'h65535, 1'b0, 16};
        vecs[12] = '{2, 16'd10000, 20'h10000, 1'b0, 16};
        vecs[13] = '{2, 16'd9,     20'h00009, 1'b0, 16};

        // Clock/reset
        rst_n     = 1'b0;
        in_bin    = '0;
        in_valid  = '0;
        out_ready = '0;
        #12;
        check("reset_in_ready",  32'(in_ready),  32'h7);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_ovf",   32'(out_ovf),   32'h0);
        check("reset_bcd_a",     32'(bcd_a),     32'h0);
        check("reset_bcd_c",     32'(bcd_c),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i].sel, vecs[i].bin, bcd, ovf, lat);
            check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure with noisy inputs while the result is held
        in_bin      = 16'd123;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'($urandom_range(0, 1));
            in_bin      = 16'($urandom);
            tick();
            check("bp_out_valid", 32'(out_valid[0]), 32'd1);
            check("bp_out_bcd",   32'(bcd_a),        32'h123);
            check("bp_in_ready",  32'(in_ready[0]),  32'd0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("bp_release_valid", 32'(out_valid[0]), 32'd0);
        check("bp_release_ready", 32'(in_ready[0]),  32'd1);
        check("bp_bcd_kept",      32'(bcd_a),        32'h123);
        tick();
        check("bp_no_restart", 32'(in_ready[0]), 32'd1);

        // Asynchronous reset after four shift cycles
        in_bin      = 16'd255;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_mid_in_ready",  32'(in_ready[0]),  32'd1);
        check("rst_mid_bcd",       32'(bcd_a),        32'h0);
        check("rst_mid_ovf",       32'(out_ovf[0]),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_post_idle", 32'(in_ready[0] & ~out_valid[0]), 32'd1);
        run_vec(0, 16'd42, bcd, ovf, lat);
        check("rst_post_bcd", 32'(bcd), 32'h042);
        check("rst_post_ovf", 32'(ovf), 32'd0);

        // Random operands on the narrow and wide configurations
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom_range(0, 255));
            run_vec(1, {8'h0, r}, bcd, ovf, lat);
            exp = ref_bcd(r, 2);
            check("rand_b_bcd", 32'(bcd), 32'(exp[19:0]));
            check("rand_b_ovf", 32'(ovf), 32'(exp[20]));
        end
        for (int i = 0; i < 10; i++) begin
            r16 = 16'($urandom);
            run_vec(2, r16, bcd, ovf, lat);
            exp = ref_bcd(r16, 5);
            check("rand_c_bcd", 32'(bcd), 32'(exp[19:0]));
            check("rand_c_ovf", 32'(ovf), 32'(exp[20]));
            check("rand_c_lat", 32'(lat), 32'd16);
        end

        // Back-to-back stream with both handshakes held open
        begin
            logic [11:0] exp_q[$];
            logic [11:0] e;
            int sent, recv, cyc, last_acc;
            sent = 0; recv = 0; cyc = 0; last_acc = -1;
            out_ready[0] = 1'b1;
            while (recv < 50 && cyc < 1000) begin
                if (out_valid[0]) begin
                    if (exp_q.size() == 0) begin
                        check("stream_spurious", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_bcd", 32'(bcd_a), 32'(e));
                        check("stream_ovf", 32'(out_ovf[0]), 32'd0);
                    end
                    recv++;
                end
                if (in_ready[0]) begin
                    if (sent < 50) begin
                        r = 8'($urandom_range(0, 255));
                        in_bin      = {8'h0, r};
                        in_valid[0] = 1'b1;
                        exp = ref_bcd(r, 3);
                        exp_q.push_back(exp[11:0]);
                        if (last_acc >= 0) check("stream_spacing", 32'(cyc - last_acc), 32'd10);
                        last_acc = cyc;
                        sent++;
                    end else begin
                        in_valid[0] = 1'b0;
                    end
                end
                tick();
                cyc++;
            end
            in_valid[0]  = 1'b0;
            out_ready[0] = 1'b0;
            check("stream_count", 32'(recv), 32'd50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
